tlb_maint_ctrl: RTL and testbench

TLB_MAINT_CTRL -- requirements
Module: tlb_maint_ctrl

---
 rtl/tlb_maint_ctrl.sv | 164 ++++++++++++++++
 tb/tb_tlb_maint_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance controller for the CP0 TLBP / TLBR / TLBWI / TLBWR instructions.
// Each accepted op walks IDLE -> EXEC -> FIN. The operands are frozen into tlb_cfg at accept.
// Writes strobe tlb_we in EXEC. Probes and reads return their CP0 write-backs in FIN.
// The Random register free-runs beside the FSM and supplies the slot used by TLBWR.
module tlb_maint_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  output logic        op_ready,
  output logic        op_done,
  input  logic [31:0] entryhi_in,
  input  logic [31:0] entrylo0_in,
  input  logic [31:0] entrylo1_in,
  input  logic [3:0]  index_in,
  input  logic [3:0]  wired_in,
  input  logic        wired_we,
  output logic [89:0] tlb_cfg,
  output logic        tlb_we,
  input  logic [31:0] probe_result,
  output logic [3:0]  rd_idx,
  input  logic [85:0] rd_entry,
  output logic        index_we,
  output logic [31:0] index_out,
  output logic        entryhi_we,
  output logic [31:0] entryhi_out,
  output logic        lo0_we,
  output logic [31:0] lo0_out,
  output logic        lo1_we,
  output logic [31:0] lo1_out,
  output logic [3:0]  random_out
);

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_FIN} state_t;

  state_t      state_reg;
  logic [1:0]  op_reg;
  logic [3:0]  random_reg;

  // Operand capture: TLBWR targets whatever Random holds in the accept cycle.
  logic [3:0]  acc_idx;
  logic [89:0] cfg_new;

  assign acc_idx = (op_code == OP_TLBWR) ? random_reg : index_in;
  assign cfg_new = {entrylo0_in[5:3], entrylo1_in[5:3], entryhi_in[7:0],
                    entrylo0_in[0] & entrylo1_in[0], entryhi_in[31:13],
                    entrylo1_in[29:6], entrylo1_in[2], entrylo1_in[1],
                    entrylo0_in[29:6], entrylo0_in[2], entrylo0_in[1], acc_idx};

  // Read-back formatting of the entry at rd_idx (same layout as tlb_cfg[89:4]).
  logic [2:0]  re_c0, re_c1;
  logic [7:0]  re_asid;
  logic        re_g, re_d1, re_v1, re_d0, re_v0;
  logic [18:0] re_vpn2;
  logic [23:0] re_pfn1, re_pfn0;
  logic [31:0] hi_rb, lo0_rb, lo1_rb, idx_rb;
  logic        probe_miss;

  assign re_c0      = rd_entry[85:83];
  assign re_c1      = rd_entry[82:80];
  assign re_asid    = rd_entry[79:72];
  assign re_g       = rd_entry[71];
  assign re_vpn2    = rd_entry[70:52];
  assign re_pfn1    = rd_entry[51:28];
  assign re_d1      = rd_entry[27];
  assign re_v1      = rd_entry[26];
  assign re_pfn0    = rd_entry[25:2];
  assign re_d0      = rd_entry[1];
  assign re_v0      = rd_entry[0];

  assign hi_rb      = {re_vpn2, 5'b0, re_asid};
  assign lo0_rb     = {2'b0, re_pfn0, re_c0, re_d0, re_v0, re_g};
  assign lo1_rb     = {2'b0, re_pfn1, re_c1, re_d1, re_v1, re_g};

  // A miss reports only the miss flag; the hit index field is forced to zero.
  assign probe_miss = probe_result[31];
  assign idx_rb     = {probe_miss, 27'b0, probe_miss ? 4'b0 : probe_result[3:0]};

  // Operand bits that the TLB format does not carry.
  logic unused_bits;
  assign unused_bits = ^{entryhi_in[12:8], entrylo0_in[31:30], entrylo1_in[31:30],
                         probe_result[30:4]};

  // Op sequencer: all handshake, strobe and write-back outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      op_reg      <= OP_TLBP;
      op_ready    <= 1'b1;
      op_done     <= 1'b0;
      tlb_we      <= 1'b0;
      tlb_cfg     <= '0;
      rd_idx      <= '0;
      index_we    <= 1'b0;
      index_out   <= '0;
      entryhi_we  <= 1'b0;
      entryhi_out <= '0;
      lo0_we      <= 1'b0;
      lo0_out     <= '0;
      lo1_we      <= 1'b0;
      lo1_out     <= '0;
    end else begin
      tlb_we     <= 1'b0;
      op_done    <= 1'b0;
      index_we   <= 1'b0;
      entryhi_we <= 1'b0;
      lo0_we     <= 1'b0;
      lo1_we     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (op_valid) begin
            op_reg    <= op_code;
            tlb_cfg   <= cfg_new;
            rd_idx    <= acc_idx;
            tlb_we    <= op_code[1];
            op_ready  <= 1'b0;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          op_done   <= 1'b1;
          state_reg <= ST_FIN;
          if (op_reg == OP_TLBP) begin
            index_we  <= 1'b1;
            index_out <= idx_rb;
          end else if (op_reg == OP_TLBR) begin
            entryhi_we  <= 1'b1;
            entryhi_out <= hi_rb;
            lo0_we      <= 1'b1;
            lo0_out     <= lo0_rb;
            lo1_we      <= 1'b1;
            lo1_out     <= lo1_rb;
          end
        end
        ST_FIN: begin
          op_ready  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          op_ready  <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Random register: counts down, wraps to 15 at or below Wired, and restarts on a Wired write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      random_reg <= 4'd15;
    end else if (wired_we || (random_reg <= wired_in)) begin
      random_reg <= 4'd15;
    end else begin
      random_reg <= random_reg - 4'd1;
    end
  end

  assign random_out = random_reg;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Bench for tlb_maint_ctrl: directed vector table, hand-written multi-cycle sequences,
// then randomized ops checked against a field-level TLB / CP0 model.
module tb_tlb_maint_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [1:0]  op_code;
  logic        op_ready, op_done;
  logic [31:0] entryhi_in, entrylo0_in, entrylo1_in;
  logic [3:0]  index_in, wired_in;
  logic        wired_we;
  logic [89:0] tlb_cfg;
  logic        tlb_we;
  logic [31:0] probe_result;
  logic [3:0]  rd_idx;
  logic [85:0] rd_entry;
  logic        index_we, entryhi_we, lo0_we, lo1_we;
  logic [31:0] index_out, entryhi_out, lo0_out, lo1_out;
  logic [3:0]  random_out;

  always #5 clk = ~clk;

  tlb_maint_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .op_done(op_done), .entryhi_in(entryhi_in),
    .entrylo0_in(entrylo0_in), .entrylo1_in(entrylo1_in), .index_in(index_in),
    .wired_in(wired_in), .wired_we(wired_we), .tlb_cfg(tlb_cfg), .tlb_we(tlb_we),
    .probe_result(probe_result), .rd_idx(rd_idx), .rd_entry(rd_entry),
    .index_we(index_we), .index_out(index_out), .entryhi_we(entryhi_we),
    .entryhi_out(entryhi_out), .lo0_we(lo0_we), .lo0_out(lo0_out),
    .lo1_we(lo1_we), .lo1_out(lo1_out), .random_out(random_out)
  );

  // TLB model: each slot holds the full config word written to it (entry = [89:4]).
  logic [89:0] tlb_m [16];
  assign rd_entry = tlb_m[rd_idx][89:4];

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [89:0] act, input logic [89:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Random register model, stepped from the driven inputs.
  logic [3:0] rnd_m;
  always @(posedge clk) begin
    if (!rst_n || wired_we || rnd_m <= wired_in) rnd_m <= 4'd15;
    else rnd_m <= rnd_m - 4'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk("random_out", random_out, rnd_m);
  endtask

  // Config word built field by field from the CP0 operands.
  function automatic logic [89:0] cfg_of(input logic [31:0] hi, input logic [31:0] lo0,
                                         input logic [31:0] lo1, input logic [3:0] idx);
    logic [89:0] r;
    r = 90'(idx);
    r = r | (90'((lo0 >> 1) & 1) << 4)  | (90'((lo0 >> 2) & 1) << 5);
    r = r | (90'((lo0 >> 6) & 32'hFFFFFF) << 6);
    r = r | (90'((lo1 >> 1) & 1) << 30) | (90'((lo1 >> 2) & 1) << 31);
    r = r | (90'((lo1 >> 6) & 32'hFFFFFF) << 32);
    r = r | (90'(hi >> 13) << 56);
    r = r | (90'(lo0 & lo1 & 1) << 75);
    r = r | (90'(hi & 32'hFF) << 76);
    r = r | (90'((lo1 >> 3) & 7) << 84) | (90'((lo0 >> 3) & 7) << 87);
    return r;
  endfunction

  function automatic logic [31:0] hi_of(input logic [89:0] e);
    return (32'((e >> 56) & 90'h7FFFF) << 13) | 32'((e >> 76) & 90'hFF);
  endfunction

  // half = 0 for EntryLo0, 1 for EntryLo1.
  function automatic logic [31:0] lo_of(input logic [89:0] e, input int half);
    logic [31:0] pfn, c, d, v, g;
    pfn = 32'((e >> (half ? 32 : 6)) & 90'hFFFFFF);
    c   = 32'((e >> (half ? 84 : 87)) & 90'h7);
    d   = 32'((e >> (half ? 31 : 5)) & 90'h1);
    v   = 32'((e >> (half ? 30 : 4)) & 90'h1);
    g   = 32'((e >> 75) & 90'h1);
    return (pfn << 6) | (c << 3) | (d << 2) | (v << 1) | g;
  endfunction

  // Expected held write-back registers.
  logic [31:0] e_idx_out, e_hi, e_lo0, e_lo1;
  logic [89:0] e_cfg;

  task automatic do_op(input logic [1:0] code, input logic [31:0] hi, input logic [31:0] lo0,
                       input logic [31:0] lo1, input logic [3:0] idx, input logic [31:0] probe,
                       input logic ww, output logic [89:0] cfg_seen);
    logic [3:0] eidx;
    int guard;
    guard = 0;
    while (!op_ready && guard < 10) begin
      step();
      guard++;
    end
    chk("ready_wait", op_ready, 1'b1);
    op_valid = 1'b1; op_code = code; entryhi_in = hi; entrylo0_in = lo0;
    entrylo1_in = lo1; index_in = idx; probe_result = probe;
    eidx  = (code == 2'd3) ? rnd_m : idx;
    e_cfg = cfg_of(hi, lo0, lo1, eidx);
    step();
    // EXEC: operands must already be frozen, so scramble the live inputs.
    op_valid = 1'b0; wired_we = ww;
    entryhi_in = $urandom; entrylo0_in = $urandom; entrylo1_in = $urandom;
    index_in = 4'($urandom); op_code = 2'($urandom);
    cfg_seen = tlb_cfg;
    chk("exec_ready", op_ready, 1'b0);
    chk("exec_done", op_done, 1'b0);
    chk("exec_tlb_we", tlb_we, code[1]);
    chk("exec_cfg", tlb_cfg, e_cfg);
    chk("exec_wbs", {index_we, entryhi_we, lo0_we, lo1_we}, 4'b0);
    if (code == 2'd1) chk("exec_rd_idx", rd_idx, eidx);
    if (code[1]) tlb_m[eidx] = e_cfg;
    step();
    // FIN
    wired_we = 1'b0;
    if (code == 2'd0) e_idx_out = probe[31] ? 32'h8000_0000 : (probe & 32'hF);
    if (code == 2'd1) begin
      e_hi  = hi_of(tlb_m[eidx]);
      e_lo0 = lo_of(tlb_m[eidx], 0);
      e_lo1 = lo_of(tlb_m[eidx], 1);
    end
    chk("fin_done", op_done, 1'b1);
    chk("fin_ready", op_ready, 1'b0);
    chk("fin_tlb_we", tlb_we, 1'b0);
    chk("fin_index_we", index_we, code == 2'd0);
    chk("fin_hilo_we", {entryhi_we, lo0_we, lo1_we}, (code == 2'd1) ? 3'b111 : 3'b000);
    chk("fin_index_out", index_out, e_idx_out);
    chk("fin_wb", {entryhi_out, lo0_out, lo1_out}, {e_hi, e_lo0, e_lo1});
    chk("fin_cfg", tlb_cfg, e_cfg);
    step();
    // Back in IDLE: strobes gone, data held.
    chk("idle_ready", op_ready, 1'b1);
    chk("idle_strobes", {op_done, tlb_we, index_we, entryhi_we, lo0_we, lo1_we}, 6'b0);
    chk("idle_hold", {index_out, entryhi_out, lo0_out, lo1_out},
        {e_idx_out, e_hi, e_lo0, e_lo1});
    chk("idle_cfg", tlb_cfg, e_cfg);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, op_ready, 1'b1);
    chk({tag, "_strobes"}, {op_done, tlb_we, index_we, entryhi_we, lo0_we, lo1_we}, 6'b0);
    chk({tag, "_cfg"}, tlb_cfg, 90'b0);
    chk({tag, "_rd_idx"}, rd_idx, 4'b0);
    chk({tag, "_outs"}, {index_out, entryhi_out, lo0_out, lo1_out}, 128'b0);
    chk({tag, "_random"}, random_out, 4'd15);
  endtask

  typedef struct {
    logic [1:0]  code;
    logic [31:0] hi, lo0, lo1;
    logic [3:0]  idx;
    logic [31:0] probe;
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [23:0] pfn0;
    logic [2:0]  c0;
    logic        d0, v0;
    logic [3:0]  cidx;
    logic [31:0] wb_idx, wb_hi, wb_lo0, wb_lo1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [89:0] cfg;
    logic [3:0]  seq [6];
    logic [1:0]  rc;
    int          guard;

    for (int i = 0; i < 16; i++) tlb_m[i] = '0;
    e_idx_out = '0; e_hi = '0; e_lo0 = '0; e_lo1 = '0; e_cfg = '0;

    vecs[0] = '{2'd2, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087, 4'd3, 32'h0,
                19'h00201, 8'h05, 1'b1, 24'h000041, 3'd0, 1'b1, 1'b1, 4'd3,
                32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{2'd0, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087, 4'd7, 32'h0000_0003,
                19'h00201, 8'h05, 1'b1, 24'h000041, 3'd0, 1'b1, 1'b1, 4'd7,
                32'h0000_0003, 32'h0, 32'h0, 32'h0};
    vecs[2] = '{2'd0, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087, 4'd7, 32'h8000_0000,
                19'h00201, 8'h05, 1'b1, 24'h000041, 3'd0, 1'b1, 1'b1, 4'd7,
                32'h8000_0000, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{2'd0, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087, 4'd7, 32'h8000_7FF5,
                19'h00201, 8'h05, 1'b1, 24'h000041, 3'd0, 1'b1, 1'b1, 4'd7,
                32'h8000_0000, 32'h0, 32'h0, 32'h0};
    vecs[4] = '{2'd1, 32'h0, 32'h0, 32'h0, 4'd3, 32'h0,
                19'h0, 8'h0, 1'b0, 24'h0, 3'd0, 1'b0, 1'b0, 4'd3,
                32'h0, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087};
    vecs[5] = '{2'd2, 32'hFFFF_E0FF, 32'h3FFF_FFFE, 32'h3FFF_FFFF, 4'd15, 32'h0,
                19'h7FFFF, 8'hFF, 1'b0, 24'hFFFFFF, 3'd7, 1'b1, 1'b1, 4'd15,
                32'h0, 32'h0, 32'h0, 32'h0};
    vecs[6] = '{2'd1, 32'h0, 32'h0, 32'h0, 4'd15, 32'h0,
                19'h0, 8'h0, 1'b0, 24'h0, 3'd0, 1'b0, 1'b0, 4'd15,
                32'h0, 32'hFFFF_E0FF, 32'h3FFF_FFFE, 32'h3FFF_FFFE};

    rst_n = 1'b0; op_valid = 1'b0; op_code = 2'd0; entryhi_in = '0; entrylo0_in = '0;
    entrylo1_in = '0; index_in = '0; wired_in = '0; wired_we = 1'b0; probe_result = '0;
    step();
    step();
    chk_reset_state("reset");

    // Random sequence with Wired = 12.
    wired_in = 4'd12;
    rst_n = 1'b1;
    seq = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd15, 4'd14};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("random_seq%0d", i), random_out, seq[i]);
      if (i < 5) step();
    end
    wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    chk("random_wired_we", random_out, 4'd15);
    guard = 0;
    while (rnd_m != 4'd13 && guard < 20) begin
      step();
      guard++;
    end
    chk("random_at_13", random_out, 4'd13);
    // TLBWR with a Wired write landing during EXEC: slot must stay 13.
    do_op(2'd3, 32'h1234_5678, 32'h0000_0FFF, 32'h0000_0041, 4'd2, 32'h0, 1'b1, cfg);
    chk("tlbwr_idx13", cfg[3:0], 4'd13);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].code, vecs[i].hi, vecs[i].lo0, vecs[i].lo1, vecs[i].idx,
            vecs[i].probe, 1'b0, cfg);
      chk($sformatf("vec%0d_vpn2", i), cfg[74:56], vecs[i].vpn2);
      chk($sformatf("vec%0d_asid", i), cfg[83:76], vecs[i].asid);
      chk($sformatf("vec%0d_g", i), cfg[75], vecs[i].g);
      chk($sformatf("vec%0d_pfn0", i), cfg[29:6], vecs[i].pfn0);
      chk($sformatf("vec%0d_c0d0v0", i), {cfg[89:87], cfg[5], cfg[4]},
          {vecs[i].c0, vecs[i].d0, vecs[i].v0});
      chk($sformatf("vec%0d_idx", i), cfg[3:0], vecs[i].cidx);
      if (vecs[i].code == 2'd0) chk($sformatf("vec%0d_index_out", i), index_out, vecs[i].wb_idx);
      if (vecs[i].code == 2'd1)
        chk($sformatf("vec%0d_readback", i), {entryhi_out, lo0_out, lo1_out},
            {vecs[i].wb_hi, vecs[i].wb_lo0, vecs[i].wb_lo1});
    end

    // Back-to-back: op_valid held high through the busy cycles.
    op_valid = 1'b1; op_code = 2'd0; probe_result = 32'h0000_0005;
    step();
    chk("b2b_exec1_ready", op_ready, 1'b0);
    step();
    chk("b2b_fin1_done", {op_done, op_ready}, 2'b10);
    step();
    chk("b2b_idle_ready", {op_done, op_ready}, 2'b01);
    step();
    op_valid = 1'b0;
    chk("b2b_exec2", {op_done, op_ready}, 2'b00);
    step();
    chk("b2b_fin2", {op_done, index_we, index_out}, {2'b11, 32'h0000_0005});
    e_idx_out = 32'h0000_0005;
    step();
    chk("b2b_idle2_ready", op_ready, 1'b1);

    // Reset during EXEC of a TLBWI.
    op_valid = 1'b1; op_code = 2'd2; entryhi_in = 32'hABCD_E012; entrylo0_in = 32'h0000_2047;
    entrylo1_in = 32'h0000_3047; index_in = 4'd9;
    step();
    op_valid = 1'b0;
    chk("abort_exec_tlb_we", tlb_we, 1'b1);
    tlb_m[9] = cfg_of(32'hABCD_E012, 32'h0000_2047, 32'h0000_3047, 4'd9);
    rst_n = 1'b0;
    step();
    chk_reset_state("abort");
    rst_n = 1'b1;
    e_idx_out = '0; e_hi = '0; e_lo0 = '0; e_lo1 = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("abort_quiet%0d", i),
          {op_ready, op_done, tlb_we, index_we, entryhi_we, lo0_we, lo1_we}, 7'b1000000);
    end

    // Randomized ops against the model.
    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        wired_we = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 4) == 0) wired_in = 4'($urandom);
        step();
      end
      wired_we = 1'b0;
      rc = 2'($urandom);
      do_op(rc, $urandom, $urandom, $urandom, 4'($urandom),
            ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0) | ($urandom & 32'h7FFF_FFFF),
            1'($urandom_range(0, 1)), cfg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
